lut_access_ctrl: RTL

- Client-side controller for the 32-bit single-port coefficient LUT RAM (registered address, registered output, 2-cycle read latency).
- After reset it fills the LUT from a streamed load interface (write path), then serves lookup requests over valid/ready (read path).
- Returns responses in order through a credit-protected response FIFO.
- Sits between the OpenCL custom-library kernel glue and the LUT instance; drives all LUT RAM pins.

---
 rtl/lut_access_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lut_access_ctrl.sv
// Client-side controller for the single-port coefficient LUT: streams the initial
// contents in, then serves in-order lookups through a credit-protected response FIFO.
module lut_access_ctrl #(
  parameter int DEPTH      = 3072,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  reload,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_oor,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic [31:0]           lut_data,
  output logic                  lut_rden,
  output logic                  lut_wren,
  input  logic [31:0]           lut_q
);

  // state  | meaning
  // S_LOAD | filling the LUT from the load stream, lookups blocked
  // S_RUN  | LUT valid, serving lookups; reload_pend drains before refill
  typedef enum logic {S_LOAD, S_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_AW+1:0]    FIFO_FULL = (FIFO_AW + 2)'(FIFO_DEPTH);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  reload_pend;
  logic                  s1_valid, s1_oor, s2_valid, s2_oor;

  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic                  fifo_oor  [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    fifo_wp, fifo_rp;
  logic [FIFO_AW:0]      fifo_count;
  logic                  fifo_empty, push, pop;

  logic                  in_range, fire, drained;
  logic [FIFO_AW+1:0]    outstanding;

  assign in_range    = ({1'b0, req_addr} < DEPTH_W);
  assign fire        = req_valid & req_ready;
  assign fifo_empty  = (fifo_count == '0);
  // Credits cover both pipeline stages so the FIFO can never overflow.
  assign outstanding = {1'b0, fifo_count} + (FIFO_AW + 2)'(s1_valid) + (FIFO_AW + 2)'(s2_valid);
  assign drained     = ~s1_valid & ~s2_valid & fifo_empty;
  assign lut_data    = load_data;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    lut_wren    = 1'b0;
    lut_rden    = 1'b0;
    req_ready   = 1'b0;
    lut_address = req_addr;
    case (state)
      S_LOAD: begin
        load_ready  = 1'b1;
        lut_address = wr_ptr;
        lut_wren    = load_valid;
        if (load_valid && wr_ptr == LAST_ADDR) state_nxt = S_RUN;
      end
      S_RUN: begin
        req_ready = ~reload_pend & (outstanding < FIFO_FULL);
        lut_rden  = req_valid & req_ready & in_range;
        if (reload_pend && drained) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      load_done   <= 1'b0;
      reload_pend <= 1'b0;
    end else if (state == S_LOAD) begin
      if (load_valid) begin
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr    <= '0;
          load_done <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end else begin
      if (reload) reload_pend <= 1'b1;
      if (reload_pend && drained) begin
        reload_pend <= 1'b0;
        load_done   <= 1'b0;
        wr_ptr      <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s2_valid <= 1'b0;
      s2_oor   <= 1'b0;
    end else begin
      s1_valid <= fire;
      s1_oor   <= fire & ~in_range;
      s2_valid <= s1_valid;
      s2_oor   <= s1_oor;
    end
  end

  assign push = s2_valid;
  assign pop  = ~fifo_empty & rsp_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[fifo_wp] <= s2_oor ? 32'd0 : lut_q;
      fifo_oor[fifo_wp]  <= s2_oor;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (pop)  fifo_rp <= fifo_rp + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Head entry is masked when empty so stale storage never reaches the outputs.
  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = fifo_empty ? 32'd0 : fifo_data[fifo_rp];
  assign rsp_oor   = fifo_empty ? 1'b0  : fifo_oor[fifo_rp];

endmodule
